// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bus bundle for mem_arbiter: IFU and LSU request/response
//             channels plus the single downstream memory port.
//             master = arbiter view, slave = requesters/memory view.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch channel
    logic              ifu_valid;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_ready;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_err;

    // Load/store channel
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [7:0]        lsu_wmask;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_ready;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_err;

    // Downstream memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [7:0]        mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  ifu_valid, ifu_addr,
        output ifu_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        input  lsu_valid, lsu_addr, lsu_wen, lsu_wmask, lsu_wdata,
        output lsu_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output ifu_valid, ifu_addr,
        input  ifu_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        output lsu_valid, lsu_addr, lsu_wen, lsu_wmask, lsu_wdata,
        input  lsu_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one memory port between IFU and LSU. One transaction
//             outstanding at a time, alternating priority under contention,
//             per-transaction timeout returning an error response.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    // Timer holds values up to TIMEOUT; minimum one bit when disabled.
    localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Timer value in the last allowed cycle: reaching TIMEOUT on this edge.
    localparam logic [TIMER_W-1:0] TMO_LAST =
        (TIMEOUT > 0) ? TIMER_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;     // 1: last grant went to LSU
    logic                owner_lsu_q, owner_lsu_d;   // 1: current transaction is LSU
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [7:0]          wmask_q, wmask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic                ifu_err_q, ifu_err_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                lsu_err_q, lsu_err_d;

    logic                w_idle;
    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_timeout;
    logic [TIMER_W-1:0]  w_timer_inc;
    logic                w_resp_load;
    logic [DATA_W-1:0]   w_resp_data;
    logic                w_resp_err;

    // Grant decision: the requester not served last wins a contested cycle.
    // Grants are suppressed while reset is asserted so no handshake is lost.
    assign w_idle      = (state_q == S_IDLE) && !rst;
    assign w_grant_lsu = w_idle && bus.lsu_valid && (!bus.ifu_valid || !last_lsu_q);
    assign w_grant_ifu = w_idle && bus.ifu_valid && !w_grant_lsu;

    // Saturating increment and timeout detection.
    assign w_timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign w_timeout   = (TIMEOUT != 0) && (timer_q >= TMO_LAST);

    // Next-state, request latch and response capture.
    always_comb begin
        state_d     = state_q;
        last_lsu_d  = last_lsu_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        timer_d     = timer_q;
        ifu_rdata_d = ifu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_rdata_d = lsu_rdata_q;
        lsu_err_d   = lsu_err_q;
        w_resp_load = 1'b0;
        w_resp_data = '0;
        w_resp_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_grant_lsu) begin
                    owner_lsu_d = 1'b1;
                    last_lsu_d  = 1'b1;
                    addr_d      = bus.lsu_addr;
                    wen_d       = bus.lsu_wen;
                    wmask_d     = bus.lsu_wmask;
                    wdata_d     = bus.lsu_wdata;
                    timer_d     = '0;
                    state_d     = S_ISSUE;
                end else if (w_grant_ifu) begin
                    // Fetches are always reads.
                    owner_lsu_d = 1'b0;
                    last_lsu_d  = 1'b0;
                    addr_d      = bus.ifu_addr;
                    wen_d       = 1'b0;
                    wmask_d     = '0;
                    wdata_d     = '0;
                    timer_d     = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = w_timer_inc;
                // A response in the acceptance cycle is ignored by design.
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                end else if (w_timeout) begin
                    w_resp_load = 1'b1;
                    w_resp_err  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WAIT: begin
                timer_d = w_timer_inc;
                // A response on the timeout edge still counts as good data.
                if (bus.mem_resp_valid) begin
                    w_resp_load = 1'b1;
                    w_resp_data = bus.mem_rdata;
                    state_d     = S_RESP;
                end else if (w_timeout) begin
                    w_resp_load = 1'b1;
                    w_resp_err  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only the owner's held response registers are updated.
        if (w_resp_load) begin
            if (owner_lsu_q) begin
                lsu_rdata_d = w_resp_data;
                lsu_err_d   = w_resp_err;
            end else begin
                ifu_rdata_d = w_resp_data;
                ifu_err_d   = w_resp_err;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_lsu_q  <= 1'b0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            timer_q     <= '0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            timer_q     <= timer_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign bus.ifu_ready      = w_grant_ifu;
    assign bus.lsu_ready      = w_grant_lsu;
    assign bus.ifu_resp_valid = (state_q == S_RESP) && !rst && !owner_lsu_q;
    assign bus.lsu_resp_valid = (state_q == S_RESP) && !rst &&  owner_lsu_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_err        = ifu_err_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_err        = lsu_err_q;

    assign bus.mem_req_valid  = (state_q == S_ISSUE) && !rst;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wmask      = wmask_q;
    assign bus.mem_wdata      = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (TIMEOUT = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    logic seen;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_valid      = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_valid      = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wmask      = '0;
        bus.lsu_wdata      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        clear_inputs();
        tick();
        tick();

        // ---------------- reset state ----------------
        #1;
        check("rst_ctrl",
              {bus.ifu_ready, bus.lsu_ready, bus.mem_req_valid, bus.ifu_resp_valid,
               bus.lsu_resp_valid, bus.ifu_err, bus.lsu_err, bus.mem_wen}, 8'h00);
        check("rst_data", {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
        check("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        check("rst_wmask", bus.mem_wmask, 8'h00);
        tick();
        rst = 1'b0;

        // ---------------- single fetch ----------------
        tick();                                   // cycle 0
        bus.ifu_valid = 1'b1;
        bus.ifu_addr  = 32'h8000_0000;
        #1;
        check("fetch_ready", {bus.ifu_ready, bus.lsu_ready}, 2'b10);
        tick();                                   // cycle 1
        bus.ifu_valid     = 1'b0;
        bus.ifu_addr      = 32'h0;
        bus.mem_req_ready = 1'b1;
        #1;
        check("fetch_issue", {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}, 10'b1_0_00000000);
        check("fetch_addr", bus.mem_addr, 32'h8000_0000);
        tick();                                   // cycle 2
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0010_0093;
        #1;
        check("fetch_wait", {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}, 3'b000);
        tick();                                   // cycle 3
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        #1;
        check("fetch_resp", {bus.ifu_resp_valid, bus.ifu_err, bus.lsu_resp_valid}, 3'b100);
        check("fetch_rdata", bus.ifu_rdata, 32'h0010_0093);
        tick();                                   // cycle 4
        #1;
        check("fetch_hold", {bus.ifu_resp_valid, bus.ifu_rdata}, {1'b0, 32'h0010_0093});

        // ---------------- contention and fairness ----------------
        pulse_reset();
        bus.ifu_valid = 1'b1;
        bus.ifu_addr  = 32'h0000_0200;
        bus.lsu_valid = 1'b1;
        bus.lsu_addr  = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            exp_lsu = (k % 2 == 0);
            #1;                                    // grant cycle
            check($sformatf("fair_grant%0d", k), {bus.lsu_ready, bus.ifu_ready}, {exp_lsu, !exp_lsu});
            tick();                                // issue
            bus.mem_req_ready = 1'b1;
            #1;
            check($sformatf("fair_addr%0d", k), {bus.mem_req_valid, bus.mem_addr},
                  {1'b1, (exp_lsu ? 32'h0000_0100 : 32'h0000_0200)});
            tick();                                // wait
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 32'hA0 + k;
            tick();                                // resp
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = 32'h0;
            #1;
            check($sformatf("fair_resp%0d", k), {bus.lsu_resp_valid, bus.ifu_resp_valid},
                  {exp_lsu, !exp_lsu});
            check($sformatf("fair_rdata%0d", k), (exp_lsu ? bus.lsu_rdata : bus.ifu_rdata), 32'hA0 + k);
            tick();                                // next grant cycle
        end
        bus.ifu_valid = 1'b0;
        bus.lsu_valid = 1'b0;

        // ---------------- store with back-pressure ----------------
        tick();
        bus.lsu_valid = 1'b1;
        bus.lsu_wen   = 1'b1;
        bus.lsu_wmask = 8'h03;
        bus.lsu_wdata = 32'h0000_BEEF;
        bus.lsu_addr  = 32'h8000_1002;
        #1;
        check("store_ready", {bus.lsu_ready, bus.ifu_ready}, 2'b10);
        seen = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            // Scramble the source fields: the arbiter must use its latched copy.
            bus.lsu_valid = 1'b0;
            bus.lsu_wen   = 1'b0;
            bus.lsu_wmask = 8'hF0;
            bus.lsu_wdata = 32'h1234_5678;
            bus.lsu_addr  = 32'h0;
            #1;
            if (!(bus.mem_req_valid && bus.mem_wen && bus.mem_wmask == 8'h03 &&
                  bus.mem_wdata == 32'h0000_BEEF && bus.mem_addr == 32'h8000_1002))
                seen = 1'b0;
        end
        check("store_held", seen, 1'b1);
        tick();
        bus.mem_req_ready = 1'b1;
        #1;
        check("store_accept", {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}, {1'b1, 1'b1, 8'h03});
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_1111;
        #1;
        check("store_wait", {bus.mem_req_valid, bus.lsu_resp_valid}, 2'b00);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        #1;
        check("store_resp", {bus.lsu_resp_valid, bus.lsu_err, bus.ifu_resp_valid}, 3'b100);

        // ---------------- timeout ----------------
        tick();
        bus.lsu_valid = 1'b1;
        bus.lsu_wen   = 1'b0;
        bus.lsu_wmask = 8'h00;
        bus.lsu_wdata = 32'h0;
        bus.lsu_addr  = 32'h0000_0300;
        #1;
        check("tmo_ready", bus.lsu_ready, 1'b1);
        seen = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            bus.lsu_valid     = 1'b0;
            bus.mem_req_ready = (c == 1);
            bus.mem_rdata     = 32'h5555_5555;
            #1;
            if (bus.lsu_resp_valid || bus.ifu_resp_valid) seen = 1'b1;
        end
        check("tmo_early", seen, 1'b0);
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        check("tmo_resp", {bus.lsu_resp_valid, bus.lsu_err, bus.ifu_resp_valid}, 3'b110);
        check("tmo_rdata", bus.lsu_rdata, 32'h0);
        tick();
        bus.mem_resp_valid = 1'b1;                 // late response
        bus.mem_rdata      = 32'h0000_DEAD;
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("tmo_late", {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_req_valid}, 3'b000);
        check("tmo_hold", {bus.lsu_err, bus.lsu_rdata}, {1'b1, 32'h0});

        // ---------------- reset mid-WAIT ----------------
        tick();
        bus.ifu_valid = 1'b1;
        bus.ifu_addr  = 32'h0000_0400;
        #1;
        check("rw_ready", bus.ifu_ready, 1'b1);
        tick();
        bus.ifu_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();                                    // WAIT
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0077;
        #1;
        check("rw_ctrl",
              {bus.ifu_ready, bus.lsu_ready, bus.mem_req_valid, bus.ifu_resp_valid,
               bus.lsu_resp_valid, bus.ifu_err, bus.lsu_err, bus.mem_wen}, 8'h00);
        check("rw_data", {bus.ifu_rdata, bus.lsu_rdata, bus.mem_addr}, 96'h0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        bus.ifu_valid      = 1'b1;
        bus.ifu_addr       = 32'h0000_0500;
        #1;
        check("rw_ignored", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        check("rw_new_ready", bus.ifu_ready, 1'b1);
        tick();
        bus.ifu_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        check("rw_new_addr", bus.mem_addr, 32'h0000_0500);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("rw_new_resp", {bus.ifu_resp_valid, bus.ifu_err, bus.ifu_rdata}, {2'b10, 32'h1234_5678});

        // ---------------- stray response in IDLE ----------------
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0BAD;
        #1;
        check("stray_now", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 3'b000);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.ifu_valid      = 1'b1;
        bus.ifu_addr       = 32'h0000_0600;
        #1;
        check("stray_after", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        check("stray_idle", bus.ifu_ready, 1'b1);
        check("stray_rdata", bus.ifu_rdata, 32'h1234_5678);
        tick();
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
